dth_seq: RTL

- Sequential BCD-to-binary converter ("decimal to hex"). It is the inverse of the team's hex-to-decimal block.
- Accepts one packed BCD word per write strobe and converts it with an iterative reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- Emits the binary result with a one-cycle write strobe.
- Sits on the same strobe-based data path as the encoder, so its output can be fed back to the encoder for loopback checks.

---
 rtl/dth_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dth_seq.sv
// dth_seq: sequential BCD-to-binary converter using iterative reverse double-dabble.
// One packed BCD word is accepted per write strobe. Each conversion step shifts the
// {bcd,bin} register right and corrects any BCD digit of 8 or more by subtracting 3.
// Words containing a digit above 9 are flagged right away without converting.
module dth_seq #(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   iv_data,
  input  logic                  i_data_wr,
  output logic [BIN_WIDTH-1:0]  ov_data,
  output logic                  o_data_wr,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_drop
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 wr_q, wr_d;
  logic                 drop_q, drop_d;

  logic                 digitsOk;
  logic                 lastIter;
  logic [SR_W-1:0]      shifted;
  logic [SR_W-1:0]      stepVal;

  assign lastIter = (state_q == CONV) && (cnt_q == CNT_W'(BIN_WIDTH - 1));

  // Flag the incoming word as convertible only when every digit is a legal BCD value.
  always_comb begin
    digitsOk = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (iv_data[4*k +: 4] > 4'd9) begin
        digitsOk = 1'b0;
      end
    end
  end

  // One conversion step: shift the whole register right, then pull each BCD digit >= 8 back by 3.
  always_comb begin
    shifted = sr_q >> 1;
    stepVal = shifted;
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted[BIN_WIDTH + 4*k +: 4] >= 4'd8) begin
        stepVal[BIN_WIDTH + 4*k +: 4] = shifted[BIN_WIDTH + 4*k +: 4] - 4'd3;
      end
    end
  end

  // State register; an asynchronous reset abandons any conversion in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only valid words start a conversion, and the final iteration returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_data_wr && digitsOk) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (lastIter) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output decode: load, iterate, publish results, and flag strobes that arrive while busy.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    err_d  = err_q;
    wr_d   = 1'b0;
    drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_data_wr) begin
          if (digitsOk) begin
            sr_d  = {iv_data, {BIN_WIDTH{1'b0}}};
            cnt_d = '0;
          end else begin
            data_d = {BIN_WIDTH{1'b1}};
            err_d  = 1'b1;
            wr_d   = 1'b1;
          end
        end
      end
      CONV: begin
        sr_d   = stepVal;
        cnt_d  = cnt_q + CNT_W'(1);
        drop_d = i_data_wr;
        if (lastIter) begin
          data_d = stepVal[BIN_WIDTH-1:0];
          err_d  = 1'b0;
          wr_d   = 1'b1;
          cnt_d  = '0;
        end
      end
      default: begin
        sr_d  = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers, all cleared by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
      wr_q   <= wr_d;
      drop_q <= drop_d;
    end
  end

  assign ov_data   = data_q;
  assign o_err     = err_q;
  assign o_data_wr = wr_q;
  assign o_drop    = drop_q;
  assign o_busy    = (state_q == CONV);

endmodule
